// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth sequential multiplier.
package booth_pkg;

    typedef enum logic [2:0] {BD_ZERO, BD_POS1, BD_POS2, BD_NEG1, BD_NEG2} booth_dig_t;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} mult_st_t;

    // Recode one overlapping triple {b[2i+1], b[2i], b[2i-1]} into a Booth digit.
    function automatic booth_dig_t booth_recode(input logic [2:0] bits);
        case (bits)
            3'b001, 3'b010: return BD_POS1;
            3'b011:         return BD_POS2;
            3'b100:         return BD_NEG2;
            3'b101, 3'b110: return BD_NEG1;
            default:        return BD_ZERO;
        endcase
    endfunction

    function automatic int ndig(input int w);
        return w / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_seq_mult_pp_gen.sv
// Radix-4 Booth partial-product selector: |d|*a, ones-complemented when d<0.
module booth_r4_pp_gen
    import booth_pkg::*;
#(
    parameter int W = 24
) (
    input  logic [W-1:0] a,
    input  booth_dig_t   dig,
    output logic [W+1:0] pp,
    output logic         neg
);

    logic [W+1:0] mag;

    always_comb begin
        mag = '0;
        neg = 1'b0;
        case (dig)
            BD_POS1: mag = {2'b00, a};
            BD_POS2: mag = {1'b0, a, 1'b0};
            BD_NEG1: begin
                mag = {2'b00, a};
                neg = 1'b1;
            end
            BD_NEG2: begin
                mag = {1'b0, a, 1'b0};
                neg = 1'b1;
            end
            default: mag = '0;
        endcase
        pp = neg ? ~mag : mag;
    end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Multi-cycle radix-4 Booth multiplier for unsigned significands with valid/ready on both sides.
module booth_r4_seq_mult
    import booth_pkg::*;
#(
    parameter int MANT_W       = 24,
    parameter int PP_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  kill,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MANT_W-1:0]     a,
    input  logic [MANT_W-1:0]     b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*MANT_W-1:0]   prod
);

    localparam int NDIG   = ndig(MANT_W);
    localparam int NSTEP  = (NDIG + PP_PER_CYCLE - 1) / PP_PER_CYCLE;
    localparam int STEP_W = $clog2(NSTEP + 1);
    localparam int ACC_W  = 2 * MANT_W + 3;
    localparam int BX_W   = MANT_W + 3;

    mult_st_t            state, state_next;
    logic [STEP_W-1:0]   step;
    logic [MANT_W-1:0]   a_reg;
    logic [BX_W-1:0]     b_ext;
    logic [ACC_W-1:0]    acc, acc_next;
    logic                last_step;

    booth_dig_t          digs [PP_PER_CYCLE];
    logic [MANT_W+1:0]   pps  [PP_PER_CYCLE];
    logic                negs [PP_PER_CYCLE];

    assign last_step = (step == STEP_W'(NSTEP - 1));

    // Digits past the top of the extended multiplier are forced to zero.
    always_comb begin
        for (int unsigned k = 0; k < PP_PER_CYCLE; k++) begin
            int unsigned idx;
            idx = 32'(step) * PP_PER_CYCLE + k;
            if (idx < NDIG)
                digs[k] = booth_recode(3'(b_ext >> (2 * idx)));
            else
                digs[k] = BD_ZERO;
        end
    end

    for (genvar k = 0; k < PP_PER_CYCLE; k++) begin : g_pp
        booth_r4_pp_gen #(.W(MANT_W)) u_pp (
            .a   (a_reg),
            .dig (digs[k]),
            .pp  (pps[k]),
            .neg (negs[k])
        );
    end

    // Sign extension of the ones-complement term plus the neg bit yields -|d|*a exactly.
    always_comb begin
        acc_next = acc;
        for (int unsigned k = 0; k < PP_PER_CYCLE; k++) begin
            int unsigned      idx;
            logic [ACC_W-1:0] term;
            idx  = 32'(step) * PP_PER_CYCLE + k;
            term = {{(ACC_W - MANT_W - 2){pps[k][MANT_W+1]}}, pps[k]} + ACC_W'(negs[k]);
            acc_next = acc_next + (term << (2 * idx));
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ST_RUN;
            end
            ST_RUN: if (last_step) state_next = ST_DONE;
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (kill) state_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step  <= '0;
            a_reg <= '0;
            b_ext <= '0;
            acc   <= '0;
            prod  <= '0;
        end else if (!kill) begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    a_reg <= a;
                    b_ext <= {2'b00, b, 1'b0};
                    acc   <= '0;
                    step  <= '0;
                end
                ST_RUN: begin
                    acc  <= acc_next;
                    step <= step + STEP_W'(1);
                    if (last_step) prod <= acc_next[2*MANT_W-1:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == ST_DONE)
            assert (acc[ACC_W-1:2*MANT_W] == '0);
    end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Bench for booth_r4_seq_mult: directed scenarios at PPC=1, random operands at PPC=2 and PPC=4.
module tb_booth_r4_seq_mult;

    localparam int W     = 24;
    localparam int NI    = 3;
    localparam int NRAND = 1500;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_done = 0;

    task automatic chk(input string nm, input logic [2*W-1:0] got, input logic [2*W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, got, want, $time);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int P  = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        localparam int NS = (W / 2 + 1 + P - 1) / P;

        logic           rst = 1'b1;
        logic           kill = 1'b0;
        logic           in_valid = 1'b0;
        logic           out_ready = 1'b1;
        logic [W-1:0]   a = '0;
        logic [W-1:0]   b = '0;
        logic           in_ready, out_valid;
        logic [2*W-1:0] prod;

        booth_r4_seq_mult #(.MANT_W(W), .PP_PER_CYCLE(P)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .kill      (kill),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .prod      (prod)
        );

        // Model: cnt 0 = idle, 1..NS = computing, NS+1 = result waiting for out_ready.
        int             cnt = 0;
        logic [2*W-1:0] m_res = '0;
        logic [2*W-1:0] m_prod = '0;

        always @(posedge clk) begin
            if (rst) begin
                cnt    = 0;
                m_prod = '0;
            end else if (kill) begin
                cnt = 0;
            end else if (cnt == 0) begin
                if (in_valid) begin
                    cnt   = 1;
                    m_res = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                end
            end else if (cnt <= NS) begin
                if (cnt == NS) m_prod = m_res;
                cnt++;
            end else if (out_ready) begin
                cnt = 0;
            end
        end

        always @(negedge clk) begin
            chk($sformatf("in_ready[%0d]", g), 48'(in_ready), 48'(cnt == 0));
            chk($sformatf("out_valid[%0d]", g), 48'(out_valid), 48'(cnt == NS + 1));
            chk($sformatf("prod[%0d]", g), prod, m_prod);
        end

        task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, output int lat);
            a = x;
            b = y;
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat = 0;
            while (!out_valid && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            chk($sformatf("op_timeout[%0d]", g), 48'(out_valid), 48'(1));
        endtask

        if (g == 0) begin : g_directed
            initial begin
                int             lat;
                logic [2*W-1:0] held;
                @(posedge clk); #1;
                chk("rst_prod", prod, 48'h0);
                chk("rst_in_ready", 48'(in_ready), 48'(1));
                chk("rst_out_valid", 48'(out_valid), 48'(0));
                rst = 1'b0;

                // T1: all-ones operands and exact latency
                run_op(24'hFFFFFF, 24'hFFFFFF, lat);
                chk("t1_lat", 48'(lat), 48'(13));
                chk("t1_prod", prod, 48'hFFFFFE000001);
                @(posedge clk); #1;

                // T2
                run_op(24'h800000, 24'h800000, lat);
                chk("t2a_prod", prod, 48'h400000000000);
                @(posedge clk); #1;
                run_op(24'h800000, 24'hC00000, lat);
                chk("t2b_prod", prod, 48'h600000000000);
                @(posedge clk); #1;

                // zero operand still takes the full latency
                run_op(24'h000000, 24'hFFFFFF, lat);
                chk("zero_lat", 48'(lat), 48'(13));
                chk("zero_prod", prod, 48'h0);
                @(posedge clk); #1;

                // T3: backpressure in DONE, then immediate re-accept
                out_ready = 1'b0;
                run_op(24'hABCDEF, 24'h123457, lat);
                held = prod;
                chk("t3_prod", held, 48'(64'h0000_ABCDEF * 64'h0000_123457));
                for (int unsigned i = 0; i < 20; i++) begin
                    @(posedge clk); #1;
                    chk("t3_hold_prod", prod, held);
                    chk("t3_hold_valid", 48'(out_valid), 48'(1));
                    chk("t3_hold_ready", 48'(in_ready), 48'(0));
                end
                out_ready = 1'b1;
                @(posedge clk); #1;
                chk("t3_rel_ready", 48'(in_ready), 48'(1));
                chk("t3_rel_valid", 48'(out_valid), 48'(0));
                chk("t3_rel_prod", prod, held);
                run_op(24'd7, 24'd9, lat);
                chk("t3_next_lat", 48'(lat), 48'(13));
                chk("t3_next_prod", prod, 48'd63);
                @(posedge clk); #1;

                // T4: kill at step 5
                a = 24'h765432;
                b = 24'h9ABCDE;
                in_valid = 1'b1;
                @(posedge clk); #1;
                in_valid = 1'b0;
                repeat (5) begin @(posedge clk); #1; end
                kill = 1'b1;
                @(posedge clk); #1;
                kill = 1'b0;
                chk("t4_ready", 48'(in_ready), 48'(1));
                chk("t4_valid", 48'(out_valid), 48'(0));
                run_op(24'd3, 24'd5, lat);
                chk("t4_prod", prod, 48'd15);
                @(posedge clk); #1;

                // T5a: reset in RUN with in_valid held high
                a = 24'h0F0F0F;
                b = 24'hF0F0F0;
                in_valid = 1'b1;
                @(posedge clk); #1;
                in_valid = 1'b0;
                repeat (3) begin @(posedge clk); #1; end
                rst = 1'b1;
                in_valid = 1'b1;
                @(posedge clk); #1;
                chk("t5a_prod", prod, 48'h0);
                chk("t5a_ready", 48'(in_ready), 48'(1));
                chk("t5a_valid", 48'(out_valid), 48'(0));
                @(posedge clk); #1;
                rst = 1'b0;
                in_valid = 1'b0;
                @(posedge clk); #1;
                chk("t5a_not_accepted", 48'(in_ready), 48'(1));

                // T5b: reset in DONE
                out_ready = 1'b0;
                run_op(24'd5, 24'd6, lat);
                chk("t5b_prod_before", prod, 48'd30);
                rst = 1'b1;
                @(posedge clk); #1;
                chk("t5b_prod", prod, 48'h0);
                chk("t5b_valid", 48'(out_valid), 48'(0));
                chk("t5b_ready", 48'(in_ready), 48'(1));
                rst = 1'b0;
                out_ready = 1'b1;
                @(posedge clk); #1;
                n_done++;
            end
        end else begin : g_random
            initial begin
                logic [W-1:0] x, y;
                int           lat;
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
                for (int unsigned n = 0; n < NRAND; n++) begin
                    x = W'($urandom) | {1'b1, {(W-1){1'b0}}};
                    y = W'($urandom) | {1'b1, {(W-1){1'b0}}};
                    run_op(x, y, lat);
                    chk($sformatf("rand_lat[%0d]", g), 48'(lat), 48'(NS));
                    chk($sformatf("rand_prod[%0d]", g), prod, {{W{1'b0}}, x} * {{W{1'b0}}, y});
                    @(posedge clk); #1;
                end
                n_done++;
            end
        end
    end

    initial begin
        int unsigned t;
        t = 0;
        while (n_done < NI && t < 60000) begin
            @(posedge clk);
            t++;
        end
        chk("all_done", 48'(n_done), 48'(NI));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
